// File: rtl/holy_irq_ctrl.sv
// holy_irq_ctrl: machine-mode interrupt controller for the holy core.
// Provides the mip / mie / mstatus CSRs and drives trap requests to the core.
//
// Ports
//   clk, rst_n    : single clock domain; rst_n is synchronous, active-low
//   timer_irq     : MTIP level from holy_clint (same clock domain)
//   soft_irq      : MSIP level from holy_clint (same clock domain)
//   ext_irq       : MEIP level, asynchronous; synchronized with two flops
//   csr_we        : one-cycle CSR write strobe
//   csr_addr      : CSR address, shared by read and write
//   csr_wdata     : CSR write data
//   csr_rdata     : CSR read data, combinational from csr_addr
//   trap_req      : interrupt trap request, held until trap_ack
//   trap_cause    : mcause for the request, valid while trap_req=1
//   trap_ack      : core accepts the trap (one cycle)
//   mret          : core retired an MRET (one-cycle pulse)
//   irq_pending   : |(mip & mie), ignores mstatus.MIE; WFI wake signal
module holy_irq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        timer_irq,
  input  logic        soft_irq,
  input  logic        ext_irq,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        trap_req,
  output logic [31:0] trap_cause,
  input  logic        trap_ack,
  input  logic        mret,
  output logic        irq_pending
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;

  typedef enum logic [1:0] {IDLE, REQ, TRAP} state_t;

  state_t      state, state_next;
  logic        ext_meta, ext_s;
  logic [2:0]  mie_q, mie_next;        // {MEIE, MTIE, MSIE}
  logic        st_mie, st_mie_next;    // mstatus.MIE
  logic        st_mpie, st_mpie_next;  // mstatus.MPIE
  logic [31:0] cause_q, cause_next;
  logic [2:0]  pend;                   // {MEI, MTI, MSI}
  logic        take;
  logic [31:0] mip_word, mie_word, mstatus_word;
  logic        unused_wdata;

  // Priority MEI > MSI > MTI; only called when at least one bit is set.
  function automatic logic [31:0] pick_cause(input logic [2:0] p);
    if (p[2])      return CAUSE_MEI;
    else if (p[0]) return CAUSE_MSI;
    else           return CAUSE_MTI;
  endfunction

  assign unused_wdata = &{csr_wdata[31:12], csr_wdata[10:8], csr_wdata[6:4], csr_wdata[2:0]};

  assign pend        = {ext_s, timer_irq, soft_irq} & mie_q;
  assign irq_pending = |pend;
  assign take        = st_mie & irq_pending;
  assign trap_req    = (state == REQ);
  assign trap_cause  = cause_q;

  always_comb begin
    mip_word         = '0;
    mip_word[3]      = soft_irq;
    mip_word[7]      = timer_irq;
    mip_word[11]     = ext_s;
    mie_word         = '0;
    mie_word[3]      = mie_q[0];
    mie_word[7]      = mie_q[1];
    mie_word[11]     = mie_q[2];
    mstatus_word     = '0;
    mstatus_word[3]  = st_mie;
    mstatus_word[7]  = st_mpie;
  end

  always_comb begin
    case (csr_addr)
      ADDR_MSTATUS: csr_rdata = mstatus_word;
      ADDR_MIE:     csr_rdata = mie_word;
      ADDR_MIP:     csr_rdata = mip_word;
      default:      csr_rdata = '0;
    endcase
  end

  // Next state. Software writes are applied first so that the hardware
  // trap_ack / mret updates of MIE/MPIE override a coincident mstatus write.
  always_comb begin
    state_next   = state;
    cause_next   = cause_q;
    mie_next     = mie_q;
    st_mie_next  = st_mie;
    st_mpie_next = st_mpie;

    if (csr_we && (csr_addr == ADDR_MIE))
      mie_next = {csr_wdata[11], csr_wdata[7], csr_wdata[3]};
    if (csr_we && (csr_addr == ADDR_MSTATUS)) begin
      st_mie_next  = csr_wdata[3];
      st_mpie_next = csr_wdata[7];
    end

    case (state)
      IDLE: begin
        if (mret) begin
          st_mie_next  = st_mpie;
          st_mpie_next = 1'b1;
        end
        if (take) begin
          cause_next = pick_cause(pend);
          state_next = REQ;
        end
      end
      // Request is held regardless of pending/MIE changes; mret is ignored.
      REQ: begin
        if (trap_ack) begin
          st_mpie_next = st_mie;
          st_mie_next  = 1'b0;
          state_next   = TRAP;
        end
      end
      TRAP: begin
        if (mret) begin
          st_mie_next  = st_mpie;
          st_mpie_next = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ext_meta <= 1'b0;
      ext_s    <= 1'b0;
      mie_q    <= '0;
      st_mie   <= 1'b0;
      st_mpie  <= 1'b0;
      cause_q  <= '0;
    end else begin
      // ext_irq synchronizer stage 1 -> stage 2
      ext_meta <= ext_irq;
      ext_s    <= ext_meta;
      state    <= state_next;
      mie_q    <= mie_next;
      st_mie   <= st_mie_next;
      st_mpie  <= st_mpie_next;
      cause_q  <= cause_next;
    end
  end

endmodule

// File: tb/tb_holy_irq_ctrl.sv
// tb_holy_irq_ctrl: table-driven bench for holy_irq_ctrl with a scoreboard
// queue, plus a hand-written reset-during-request sequence.
module tb_holy_irq_ctrl;

  localparam logic [31:0] C_MSI = 32'h8000_0003;
  localparam logic [31:0] C_MTI = 32'h8000_0007;
  localparam logic [31:0] C_MEI = 32'h8000_000B;

  logic        clk = 1'b0;
  logic        rst_n, timer_irq, soft_irq, ext_irq, csr_we, trap_ack, mret;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata, trap_cause;
  logic        trap_req, irq_pending;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  holy_irq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .timer_irq  (timer_irq),
    .soft_irq   (soft_irq),
    .ext_irq    (ext_irq),
    .csr_we     (csr_we),
    .csr_addr   (csr_addr),
    .csr_wdata  (csr_wdata),
    .csr_rdata  (csr_rdata),
    .trap_req   (trap_req),
    .trap_cause (trap_cause),
    .trap_ack   (trap_ack),
    .mret       (mret),
    .irq_pending(irq_pending)
  );

  typedef struct {
    logic        rn, we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        t, s, e, ack, mr;
    logic        xreq;
    logic [31:0] xcause, xrd;
    logic        xpend;
  } vec_t;

  typedef struct {
    int          idx;
    logic        xreq;
    logic [31:0] xcause, xrd;
    logic        xpend;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic add(input logic rn, input logic we, input logic [11:0] addr,
                     input logic [31:0] wdata, input logic t, input logic s,
                     input logic e, input logic ack, input logic mr,
                     input logic xreq, input logic [31:0] xcause,
                     input logic [31:0] xrd, input logic xpend);
    vec_t v;
    v.rn = rn; v.we = we; v.addr = addr; v.wdata = wdata;
    v.t = t; v.s = s; v.e = e; v.ack = ack; v.mr = mr;
    v.xreq = xreq; v.xcause = xcause; v.xrd = xrd; v.xpend = xpend;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s step %0d: got 0x%08h want 0x%08h", name, idx, got, want);
  endtask

  initial begin
    exp_t ex;
    rst_n = 1'b0; timer_irq = 1'b0; soft_irq = 1'b0; ext_irq = 1'b0;
    csr_we = 1'b0; csr_addr = '0; csr_wdata = '0; trap_ack = 1'b0; mret = 1'b0;

    //  rn we addr    wdata         t  s  e ack mr  req cause  rdata   pend
    // reset, then no trap until both enables are set
    add(0, 0, 12'h300, 32'h0,        0, 0, 0, 0, 0,  0, 0,     32'h0,   0);
    add(0, 0, 12'h304, 32'h0,        1, 0, 0, 0, 0,  0, 0,     32'h0,   0);
    add(1, 0, 12'h344, 32'h0,        1, 0, 0, 0, 0,  0, 0,     32'h80,  0);
    add(1, 1, 12'h304, 32'hFFFFFFFF, 1, 0, 0, 0, 0,  0, 0,     32'h888, 1);
    add(1, 0, 12'h304, 32'h0,        1, 0, 0, 0, 0,  0, 0,     32'h888, 1);
    // basic timer trap
    add(1, 1, 12'h304, 32'h80,       1, 0, 0, 0, 0,  0, 0,     32'h80,  1);
    add(1, 1, 12'h300, 32'h8,        1, 0, 0, 0, 0,  0, 0,     32'h8,   1);
    add(1, 0, 12'h300, 32'h0,        1, 0, 0, 0, 0,  1, C_MTI, 32'h8,   1);
    add(1, 0, 12'h300, 32'h0,        1, 0, 0, 1, 0,  0, 0,     32'h80,  1);
    add(1, 0, 12'h300, 32'h0,        1, 0, 0, 0, 0,  0, 0,     32'h80,  1);
    add(1, 0, 12'h300, 32'h0,        1, 0, 0, 0, 1,  0, 0,     32'h88,  1);
    add(1, 0, 12'h300, 32'h0,        1, 0, 0, 0, 0,  1, C_MTI, 32'h88,  1);
    add(1, 0, 12'h300, 32'h0,        0, 0, 0, 0, 0,  1, C_MTI, 32'h88,  0);
    add(1, 0, 12'h300, 32'h0,        0, 0, 0, 1, 0,  0, 0,     32'h80,  0);
    add(1, 0, 12'h300, 32'h0,        0, 0, 0, 0, 1,  0, 0,     32'h88,  0);
    add(1, 0, 12'h300, 32'h0,        0, 0, 0, 0, 0,  0, 0,     32'h88,  0);
    // ignored writes and unimplemented bits
    add(1, 1, 12'h344, 32'hFFFFFFFF, 0, 0, 0, 0, 0,  0, 0,     32'h0,   0);
    add(1, 1, 12'h7FF, 32'hFFFFFFFF, 0, 0, 0, 0, 0,  0, 0,     32'h0,   0);
    add(1, 1, 12'h300, 32'hFFFFFFFF, 0, 0, 0, 0, 0,  0, 0,     32'h88,  0);
    add(1, 1, 12'h300, 32'h0,        0, 0, 0, 0, 0,  0, 0,     32'h0,   0);
    add(1, 1, 12'h304, 32'h888,      0, 0, 0, 0, 0,  0, 0,     32'h888, 0);
    // priority: all three sources
    add(1, 0, 12'h344, 32'h0,        1, 1, 1, 0, 0,  0, 0,     32'h88,  1);
    add(1, 0, 12'h344, 32'h0,        1, 1, 1, 0, 0,  0, 0,     32'h888, 1);
    add(1, 1, 12'h300, 32'h8,        1, 1, 1, 0, 0,  0, 0,     32'h8,   1);
    add(1, 0, 12'h300, 32'h0,        1, 1, 1, 0, 0,  1, C_MEI, 32'h8,   1);
    add(1, 0, 12'h300, 32'h0,        1, 1, 0, 1, 0,  0, 0,     32'h80,  1);
    add(1, 0, 12'h344, 32'h0,        1, 1, 0, 0, 0,  0, 0,     32'h88,  1);
    add(1, 0, 12'h300, 32'h0,        1, 1, 0, 0, 1,  0, 0,     32'h88,  1);
    add(1, 0, 12'h300, 32'h0,        1, 1, 0, 0, 0,  1, C_MSI, 32'h88,  1);
    // no retraction; mret ignored in REQ
    add(1, 1, 12'h300, 32'h0,        0, 0, 0, 0, 0,  1, C_MSI, 32'h0,   0);
    add(1, 0, 12'h300, 32'h0,        0, 0, 0, 0, 0,  1, C_MSI, 32'h0,   0);
    add(1, 0, 12'h300, 32'h0,        0, 0, 0, 0, 1,  1, C_MSI, 32'h0,   0);
    add(1, 0, 12'h300, 32'h0,        0, 0, 0, 1, 0,  0, 0,     32'h0,   0);
    add(1, 1, 12'h300, 32'h8,        0, 0, 0, 0, 1,  0, 0,     32'h80,  0);
    // nesting blocked; ack beats mstatus write; ack outside REQ ignored
    add(1, 0, 12'h300, 32'h0,        0, 1, 0, 0, 0,  0, 0,     32'h80,  1);
    add(1, 1, 12'h300, 32'h8,        0, 1, 0, 0, 0,  0, 0,     32'h8,   1);
    add(1, 0, 12'h300, 32'h0,        0, 1, 0, 0, 0,  1, C_MSI, 32'h8,   1);
    add(1, 1, 12'h300, 32'h88,       0, 1, 0, 1, 0,  0, 0,     32'h80,  1);
    add(1, 0, 12'h300, 32'h0,        0, 1, 0, 0, 0,  0, 0,     32'h80,  1);
    add(1, 0, 12'h300, 32'h0,        0, 1, 0, 1, 0,  0, 0,     32'h80,  1);
    add(1, 0, 12'h300, 32'h0,        0, 1, 0, 0, 1,  0, 0,     32'h88,  1);
    add(1, 0, 12'h300, 32'h0,        0, 1, 0, 0, 0,  1, C_MSI, 32'h88,  1);
    add(1, 0, 12'h300, 32'h0,        0, 0, 0, 1, 0,  0, 0,     32'h80,  0);
    add(1, 0, 12'h300, 32'h0,        0, 0, 0, 0, 1,  0, 0,     32'h88,  0);
    // mret in IDLE
    add(1, 1, 12'h300, 32'h80,       0, 0, 0, 0, 0,  0, 0,     32'h80,  0);
    add(1, 0, 12'h300, 32'h0,        0, 0, 0, 0, 1,  0, 0,     32'h88,  0);
    // ext_irq two-flop latency
    add(1, 0, 12'h344, 32'h0,        0, 0, 1, 0, 0,  0, 0,     32'h0,   0);
    add(1, 0, 12'h344, 32'h0,        0, 0, 1, 0, 0,  0, 0,     32'h800, 1);
    add(1, 0, 12'h300, 32'h0,        0, 0, 1, 0, 0,  1, C_MEI, 32'h88,  1);
    add(1, 0, 12'h300, 32'h0,        0, 0, 0, 1, 0,  0, 0,     32'h80,  1);
    add(1, 0, 12'h300, 32'h0,        0, 0, 0, 0, 1,  0, 0,     32'h88,  0);
    add(1, 0, 12'h300, 32'h0,        0, 0, 0, 0, 0,  0, 0,     32'h88,  0);

    foreach (vecs[i]) begin
      rst_n = vecs[i].rn; csr_we = vecs[i].we; csr_addr = vecs[i].addr;
      csr_wdata = vecs[i].wdata; timer_irq = vecs[i].t; soft_irq = vecs[i].s;
      ext_irq = vecs[i].e; trap_ack = vecs[i].ack; mret = vecs[i].mr;
      ex.idx = i; ex.xreq = vecs[i].xreq; ex.xcause = vecs[i].xcause;
      ex.xrd = vecs[i].xrd; ex.xpend = vecs[i].xpend;
      sb.push_back(ex);
      @(posedge clk); #1;
      ex = sb.pop_front();
      check("trap_req", ex.idx, {31'b0, trap_req}, {31'b0, ex.xreq});
      check("csr_rdata", ex.idx, csr_rdata, ex.xrd);
      check("irq_pending", ex.idx, {31'b0, irq_pending}, {31'b0, ex.xpend});
      if (ex.xreq) check("trap_cause", ex.idx, trap_cause, ex.xcause);
    end

    // Reset while a request is outstanding.
    csr_we = 1'b0; trap_ack = 1'b0; mret = 1'b0; ext_irq = 1'b0; soft_irq = 1'b0;
    timer_irq = 1'b1; csr_addr = 12'h300;
    for (int k = 0; k < 8 && !trap_req; k++) begin
      @(posedge clk); #1;
    end
    check("rst_seq_req_seen", 100, {31'b0, trap_req}, 32'h1);
    check("rst_seq_cause", 100, trap_cause, C_MTI);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_trap_req", 101, {31'b0, trap_req}, 32'h0);
    check("rst_trap_cause", 101, trap_cause, 32'h0);
    check("rst_mstatus", 101, csr_rdata, 32'h0);
    csr_addr = 12'h304; #1;
    check("rst_mie", 101, csr_rdata, 32'h0);
    check("rst_irq_pending", 101, {31'b0, irq_pending}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_no_trap", 102, {31'b0, trap_req}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
